shift_req_stage: RTL and testbench

//  Buffered, registered front/back end for the 16-bit barrel shifter (barrelshifter16).

---
 rtl/shift_req_if.sv | 30 +++
 rtl/shift_req_stage.sv | 151 +++++++++++++++
 tb/tb_shift_req_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_req_if.sv
// Handshake bundle between operand issue, the shift request stage and writeback.
// Request side (in_*) and result side (out_*) each use valid/ready; fill reports queue occupancy.
// Slave modport is the stage itself, master modport is its environment.
interface shift_req_if #(
    parameter int DEPTH = 2
);
    localparam int FW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic [3:0]    in_amt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_carry;
    logic          out_zero;
    logic [FW-1:0] fill;

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero, fill
    );

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero, fill
    );
endinterface

// File: rtl/shift_req_stage.sv
// Purpose: queue shift requests, run the head through barrelshifter16, register result/carry/zero.
// Latency: accept in cycle N -> out_valid in cycle N+2; 1 result/cycle when out_ready stays high.
// Backpressure: in_ready = !full from registered state only; result held stable while !out_ready.

// Purely combinational 16-bit shifter/rotator with carry-out.
module barrelshifter16 (
    input  logic [15:0] i_data,
    input  logic [3:0]  i_amt,
    input  logic [1:0]  i_op,
    output logic [15:0] o_data,
    output logic        o_carry
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic [31:0] w_left;   // [15:0] SLL result, [16] last bit out, [31:16] wrapped bits for ROL
    logic [31:0] w_right;  // [31:16] SRL result, [15] last bit out, [15:0] wrapped bits for ROR
    logic [15:0] w_res;

    // Both directions computed on a double-width word so shift-out bits stay visible.
    always_comb begin
        w_left  = {16'h0000, i_data} << i_amt;
        w_right = {i_data, 16'h0000} >> i_amt;
        w_res   = i_data;
        o_carry = 1'b0;
        case (i_op)
            OP_SLL: begin
                w_res   = w_left[15:0];
                o_carry = w_left[16];
            end
            OP_SRL: begin
                w_res   = w_right[31:16];
                o_carry = w_right[15];
            end
            OP_ROL: begin
                w_res   = w_left[15:0] | w_left[31:16];
                o_carry = w_res[0];
            end
            OP_ROR: begin
                w_res   = w_right[31:16] | w_right[15:0];
                o_carry = w_res[15];
            end
            default: ;
        endcase
        // A zero-distance shift moves nothing out, even for rotates.
        if (i_amt == 4'd0) begin
            o_carry = 1'b0;
        end
        o_data = w_res;
    end
endmodule

module shift_req_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_req_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  amt;
        logic [1:0]  op;
    } req_t;

    req_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [FW-1:0] r_fill;
    logic          r_out_valid;
    logic [15:0]   r_out_data;
    logic          r_out_carry;
    logic          r_out_zero;

    logic          w_push;
    logic          w_load;
    logic          w_full;
    req_t          w_head;
    logic [15:0]   w_sh_data;
    logic          w_sh_carry;

    assign w_full = (r_fill == FW'(DEPTH));
    assign w_push = bus.in_valid && !w_full;
    assign w_load = (r_fill != '0) && (!r_out_valid || bus.out_ready);
    assign w_head = r_mem[r_rd_ptr];

    barrelshifter16 u_shifter (
        .i_data  (w_head.data),
        .i_amt   (w_head.amt),
        .i_op    (w_head.op),
        .o_data  (w_sh_data),
        .o_carry (w_sh_carry)
    );

    // Queue storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{data: bus.in_data, amt: bus.in_amt, op: bus.in_op};
        end
    end

    // Circular-buffer pointers and occupancy; push and pop together leave fill unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PW'((r_wr_ptr + PW'(1)) % DEPTH);
            end
            if (w_load) begin
                r_rd_ptr <= PW'((r_rd_ptr + PW'(1)) % DEPTH);
            end
            case ({w_push, w_load})
                2'b10:   r_fill <= r_fill + FW'(1);
                2'b01:   r_fill <= r_fill - FW'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Output register: load from the head when free or being drained, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sh_data;
            r_out_carry <= w_sh_carry;
            r_out_zero  <= (w_sh_data == 16'h0000);
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_carry = r_out_carry;
    assign bus.out_zero  = r_out_zero;
    assign bus.fill      = r_fill;
endmodule

// File: tb/tb_shift_req_stage.sv
module tb_shift_req_stage;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    shift_req_if #(.DEPTH(DEPTH)) bus ();

    shift_req_stage #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        c;
        logic        z;
    } exp_t;

    exp_t   exp_q[$];
    longint hs_cyc[$];
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: shift/rotate as integer multiply/divide by powers of two.
    function automatic exp_t model(input longint d, input longint n, input int op);
        longint r;
        longint c;
        exp_t   e;
        r = d;
        c = 0;
        case (op)
            0: begin r = (d * (64'd1 << n)) % 65536;               c = (n > 0) ? (d / (64'd1 << (16 - n))) % 2 : 0; end
            1: begin r = d / (64'd1 << n);                         c = (n > 0) ? (d / (64'd1 << (n - 1))) % 2 : 0; end
            2: begin r = (d * (64'd1 << n)) % 65536 + d / (64'd1 << (16 - n)); c = (n > 0) ? r % 2 : 0; end
            default: begin r = d / (64'd1 << n) + (d * (64'd1 << (16 - n))) % 65536; c = (n > 0) ? r / 32768 : 0; end
        endcase
        e.d = r[15:0];
        e.c = c[0];
        e.z = (r == 0);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: sampled mid-cycle; a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", bus.out_data, e.d);
                    chk("sb_carry", bus.out_carry, e.c);
                    chk("sb_zero", bus.out_zero, e.z);
                end
                hs_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data, bus.in_amt, bus.in_op));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic drive_req(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_op    = op;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 50);
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        next_cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.out_valid && t < 8);
        if (!bus.out_valid) chk("result_timeout", 0, 1);
    endtask

    logic [15:0] dir_d  [10] = '{16'h8001, 16'h0001, 16'h0001, 16'hF000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF, 16'h0000};
    logic [3:0]  dir_a  [10] = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd7};
    logic [1:0]  dir_op [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [15:0] dir_r  [10] = '{16'h0002, 16'h0000, 16'h1000, 16'h000F, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h8000, 16'h0000};
    logic        dir_c  [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [15:0] bp_d   [4]  = '{16'h1234, 16'h8000, 16'h0F0F, 16'hFFFF};
    logic [3:0]  bp_a   [4]  = '{4'd3, 4'd1, 4'd8, 4'd5};
    logic [1:0]  bp_op  [4]  = '{2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        int          k;
        int          base;
        logic [15:0] held;
        exp_t        e0;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_carry", bus.out_carry, 0);
        chk("rst_out_zero", bus.out_zero, 0);
        chk("rst_fill", bus.fill, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        next_cycle();

        // Latency: accepted at edge E1, out_valid must be visible only after E2.
        bus.in_valid = 1'b1; bus.in_data = 16'h8001; bus.in_amt = 4'd1; bus.in_op = 2'b00;
        @(negedge clk);
        chk("lat_accept", bus.in_ready, 1);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", bus.out_valid, 0);
        chk("lat_n1_fill", bus.fill, 1);
        @(negedge clk);
        chk("lat_n2_valid", bus.out_valid, 1);
        chk("lat_n2_data", bus.out_data, 16'h0002);
        chk("lat_n2_carry", bus.out_carry, 1);
        chk("lat_n2_zero", bus.out_zero, 0);
        next_cycle();

        // Directed vectors with independently known answers.
        for (int i = 0; i < 10; i++) begin
            drive_req(dir_d[i], dir_a[i], dir_op[i]);
            wait_out_valid();
            chk("dir_data", bus.out_data, dir_r[i]);
            chk("dir_carry", bus.out_carry, dir_c[i]);
            chk("dir_zero", bus.out_zero, (dir_r[i] == 16'h0000));
            next_cycle();
        end
        repeat (2) next_cycle();

        // Backpressure: four offered, three fit (two queued plus the output register).
        bus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bp_d[k];
                bus.in_amt   = bp_a[k];
                bus.in_op    = bp_op[k];
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) k++;
            next_cycle();
        end
        @(negedge clk);
        chk("bp_accepted", k, 3);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_fill", bus.fill, 2);
        chk("bp_out_valid", bus.out_valid, 1);
        e0 = model(bp_d[0], bp_a[0], bp_op[0]);
        chk("bp_head_data", bus.out_data, e0.d);
        held = bus.out_data;
        repeat (3) @(negedge clk);
        chk("bp_stable", bus.out_data, held);
        next_cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        base = hs_cyc.size();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_drain_valid", bus.out_valid, 1);
        end
        @(negedge clk);
        chk("bp_drain_done", bus.out_valid, 0);
        chk("bp_drain_cnt", hs_cyc.size() - base, 3);
        next_cycle();

        // Streaming: back-to-back random requests, result every cycle.
        base = hs_cyc.size();
        for (int i = 0; i < 32; i++) begin
            drive_req(16'($urandom), 4'($urandom), 2'($urandom));
        end
        repeat (5) next_cycle();
        chk("stream_cnt", hs_cyc.size() - base, 32);
        if (hs_cyc.size() - base == 32) chk("stream_span", hs_cyc[base + 31] - hs_cyc[base], 31);
        chk("stream_q_empty", exp_q.size(), 0);

        // Random output backpressure against random request pacing.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    drive_req(16'($urandom), 4'($urandom), 2'($urandom));
                    if ($urandom_range(0, 3) == 0) next_cycle();
                end
            end
            begin
                repeat (300) begin
                    next_cycle();
                    bus.out_ready = 1'($urandom);
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (6) next_cycle();
        chk("rand_q_empty", exp_q.size(), 0);

        // Asynchronous reset with a full queue and a held result.
        bus.out_ready = 1'b0;
        drive_req(16'h1111, 4'd1, 2'b00);
        drive_req(16'h2222, 4'd2, 2'b01);
        drive_req(16'h3333, 4'd3, 2'b10);
        @(negedge clk);
        chk("pre_rst_fill", bus.fill, 2);
        chk("pre_rst_valid", bus.out_valid, 1);
        next_cycle();
        rst_n = 1'b0;
        #2;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_fill", bus.fill, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_no_stale", bus.out_valid, 0);
        next_cycle();
        drive_req(16'h0F00, 4'd4, 2'b11);
        wait_out_valid();
        chk("post_rst_data", bus.out_data, 16'h00F0);
        repeat (3) next_cycle();
        chk("final_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
